// File: rtl/cmd_run_if.sv
// Command/status bundle between the command decoder and the run controller.
// The decoder side (master) drives the command strobe; the controller side
// (slave) returns the registered run status.
interface cmd_run_if #(
    parameter int CNT_W = 8,
    parameter int ERR_W = 4
);
    logic             cmd_valid;
    logic [2:0]       cmd;
    logic             clr_err;
    logic [1:0]       state;
    logic             busy;
    logic [CNT_W-1:0] run_cnt;
    logic             done;
    logic             timeout;
    logic             illegal;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output cmd_valid, cmd, clr_err,
        input  state, busy, run_cnt, done, timeout, illegal, err_cnt
    );

    modport slave (
        input  cmd_valid, cmd, clr_err,
        output state, busy, run_cnt, done, timeout, illegal, err_cnt
    );
endinterface

// File: rtl/cmd_run_ctrl.sv
// Run-control FSM fed by the idle/start/run/stop command decoder.
// Samples a 3-bit command under cmd_valid, counts cycles spent in RUN,
// forces STOP at the run-length limit and flags/counts illegal codes.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | waiting for START; run_cnt holds the last run length
//   START | one-cycle setup, run_cnt cleared, always moves to RUN
//   RUN   | counting; STOP cmd, START cmd (restart) or limit exits
//   STOP  | one-cycle wind-down, then IDLE with a done pulse
module cmd_run_ctrl #(
    parameter int CNT_W   = 8,
    parameter int MAX_RUN = 200,
    parameter int ERR_W   = 4,
    parameter bit STRICT  = 1'b1
) (
    input  logic      clk,
    input  logic      rst_n,
    cmd_run_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(MAX_RUN - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] run_q, run_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             done_q, done_d;
    logic             to_q, to_d;
    logic             ill_q, ill_d;
    logic             cmd_x;
    logic             cmd_bad;
    logic             cmd_ok;
    logic             cmd_start;
    logic             cmd_stop;

    // Decode the sampled command; X/Z bits only exist in simulation and
    // fold to a constant 0 in synthesis.
    always_comb begin
        cmd_x     = $isunknown(bus.cmd);
        cmd_bad   = bus.cmd_valid && (cmd_x || bus.cmd[2]);
        cmd_ok    = bus.cmd_valid && !cmd_bad;
        cmd_start = cmd_ok && (bus.cmd[1:0] == 2'd1);
        cmd_stop  = cmd_ok && (bus.cmd[1:0] == 2'd3);
    end

    // Next-state, counter and pulse logic; illegal commands override the
    // normal transition only when STRICT is set.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        err_d   = err_q;
        done_d  = 1'b0;
        to_d    = 1'b0;
        ill_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_start) begin
                    state_d = S_START;
                    run_d   = '0;
                end
            end
            S_START: begin
                state_d = S_RUN;
                run_d   = '0;
            end
            S_RUN: begin
                run_d = run_q + 1'b1;
                if (cmd_stop) begin
                    state_d = S_STOP;
                end else if (cmd_start) begin
                    state_d = S_START;
                    run_d   = '0;
                end else if (run_q == RUN_LAST) begin
                    state_d = S_STOP;
                    to_d    = 1'b1;
                end
            end
            S_STOP: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (cmd_bad) begin
            ill_d = 1'b1;
            if (err_q != '1) begin
                err_d = err_q + 1'b1;
            end
            if (STRICT) begin
                state_d = S_IDLE;
                run_d   = run_q;
                done_d  = 1'b0;
                to_d    = 1'b0;
            end
        end

        // Clearing wins over a same-cycle increment; the illegal pulse stays.
        if (bus.clr_err) begin
            err_d = '0;
        end
    end

    // State and output registers; reset aborts any run without pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            run_q   <= '0;
            err_q   <= '0;
            done_q  <= 1'b0;
            to_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            err_q   <= err_d;
            done_q  <= done_d;
            to_q    <= to_d;
            ill_q   <= ill_d;
        end
    end

    assign bus.state   = state_q;
    assign bus.busy    = (state_q == S_START) || (state_q == S_RUN);
    assign bus.run_cnt = run_q;
    assign bus.done    = done_q;
    assign bus.timeout = to_q;
    assign bus.illegal = ill_q;
    assign bus.err_cnt = err_q;

endmodule
